// File: rtl/vga_timing_ctrl.sv
// Raster sequencer: pixel-strobed H/V counters with registered sync, blanking,
// line/frame markers and a linear framebuffer address; starts/stops on frame edges.
module vga_timing_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int ADDR_W    = 19
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PIX_EN,
  input  logic              ENABLE,
  output logic [9:0]        HCOUNT,
  output logic [9:0]        VCOUNT,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              VIDEO_ON,
  output logic              LINE_START,
  output logic              FRAME_START,
  output logic [ADDR_W-1:0] PIX_ADDR,
  output logic              ACTIVE
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic              SYNC_ON   = (SYNC_POL != 0);
  localparam logic              SYNC_OFF  = ~SYNC_ON;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOPPING
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [9:0]        r_hcount;
  logic [9:0]        r_vcount;
  logic [9:0]        w_hcount_next;
  logic [9:0]        w_vcount_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_video_on;
  logic              r_line_start;
  logic              r_frame_start;
  logic              r_active;
  logic              w_line_start_next;
  logic              w_frame_start_next;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_run_next;
  logic              w_video_on_next;
  logic              w_hsync_next;
  logic              w_vsync_next;

  assign w_h_last = (r_hcount == H_LAST);
  assign w_v_last = (r_vcount == V_LAST);

  always_comb begin
    w_state_next       = r_state;
    w_hcount_next      = r_hcount;
    w_vcount_next      = r_vcount;
    w_addr_next        = r_addr;
    w_line_start_next  = 1'b0;
    w_frame_start_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (PIX_EN && ENABLE) begin
          w_state_next       = S_RUN;
          w_hcount_next      = '0;
          w_vcount_next      = '0;
          w_addr_next        = '0;
          w_line_start_next  = 1'b1;
          w_frame_start_next = 1'b1;
        end
      end
      default: begin
        // ENABLE only steers RUN<->STOPPING; the raster itself never pauses for it
        if (r_state == S_RUN && !ENABLE) begin
          w_state_next = S_STOPPING;
        end else if (r_state == S_STOPPING && ENABLE) begin
          w_state_next = S_RUN;
        end

        if (PIX_EN) begin
          if (w_h_last) begin
            w_hcount_next = '0;
            w_vcount_next = w_v_last ? 10'd0 : r_vcount + 10'd1;
            if (w_v_last && r_state == S_STOPPING && !ENABLE) begin
              w_state_next = S_IDLE;
            end else begin
              w_line_start_next  = 1'b1;
              w_frame_start_next = w_v_last;
            end
          end else begin
            w_hcount_next = r_hcount + 10'd1;
          end

          // Address advances past each visible pixel but saturates on the last one
          if (w_h_last && w_v_last) begin
            w_addr_next = '0;
          end else if (r_video_on && r_addr != ADDR_LAST) begin
            w_addr_next = r_addr + ADDR_ONE;
          end
        end
      end
    endcase
  end

  // Decode from the next counter values so the registered outputs align with the counters
  assign w_run_next      = (w_state_next != S_IDLE);
  assign w_video_on_next = w_run_next && (w_hcount_next < H_VIS) && (w_vcount_next < V_VIS);
  assign w_hsync_next    = (w_run_next && w_hcount_next >= HS_BEGIN && w_hcount_next <= HS_END)
                           ? SYNC_ON : SYNC_OFF;
  assign w_vsync_next    = (w_run_next && w_vcount_next >= VS_BEGIN && w_vcount_next <= VS_END)
                           ? SYNC_ON : SYNC_OFF;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state       <= S_IDLE;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_addr        <= '0;
      r_hsync       <= SYNC_OFF;
      r_vsync       <= SYNC_OFF;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_hcount      <= w_hcount_next;
      r_vcount      <= w_vcount_next;
      r_addr        <= w_addr_next;
      r_hsync       <= w_hsync_next;
      r_vsync       <= w_vsync_next;
      r_video_on    <= w_video_on_next;
      r_line_start  <= w_line_start_next;
      r_frame_start <= w_frame_start_next;
      r_active      <= w_run_next;
    end
  end

  assign HCOUNT      = r_hcount;
  assign VCOUNT      = r_vcount;
  assign HSYNC       = r_hsync;
  assign VSYNC       = r_vsync;
  assign VIDEO_ON    = r_video_on;
  assign LINE_START  = r_line_start;
  assign FRAME_START = r_frame_start;
  assign PIX_ADDR    = r_addr;
  assign ACTIVE      = r_active;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: default-size raster for line-level timing, plus a 16x10 raster
// for whole-frame, start/stop and reset-in-sync behaviour.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fails = 0;
  int cyc     = 0;

  // Default-parameter instance
  logic        rst_d, pix_en_d, enable_d;
  logic [9:0]  hc_d, vc_d;
  logic        hs_d, vs_d, vo_d, ls_d, fs_d, act_d;
  logic [18:0] addr_d;

  // Small raster: H 8+2+3+3=16, V 6+1+2+1=10, frame = 160 strobes
  logic        rst_s, pix_en_s, enable_s;
  logic [9:0]  hc_s, vc_s;
  logic        hs_s, vs_s, vo_s, ls_s, fs_s, act_s;
  logic [5:0]  addr_s;

  vga_timing_ctrl u_dut_d (
    .CLK(clk), .RST(rst_d), .PIX_EN(pix_en_d), .ENABLE(enable_d),
    .HCOUNT(hc_d), .VCOUNT(vc_d), .HSYNC(hs_d), .VSYNC(vs_d), .VIDEO_ON(vo_d),
    .LINE_START(ls_d), .FRAME_START(fs_d), .PIX_ADDR(addr_d), .ACTIVE(act_d)
  );

  vga_timing_ctrl #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(0), .ADDR_W(6)
  ) u_dut_s (
    .CLK(clk), .RST(rst_s), .PIX_EN(pix_en_s), .ENABLE(enable_s),
    .HCOUNT(hc_s), .VCOUNT(vc_s), .HSYNC(hs_s), .VSYNC(vs_s), .VIDEO_ON(vo_s),
    .LINE_START(ls_s), .FRAME_START(fs_s), .PIX_ADDR(addr_s), .ACTIVE(act_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Small-raster walker: bench position model, counts any raster discontinuity
  int s_pos = 0;
  int s_bad = 0;
  task automatic run_s(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      s_pos = (s_pos + 1) % 160;
      if (hc_s !== 10'(s_pos % 16) || vc_s !== 10'(s_pos / 16) || act_s !== 1'b1 ||
          fs_s !== (s_pos == 0)) s_bad++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int start_cyc, ls_cyc, ls_wide;
    int hs_low, hs_first, hs_last, vo_cnt, vo_max, changed;
    int fs0_cyc, fs_cyc, fs_cnt, bad_pos, bad_vo, bad_addr;
    int vs_low, vs_first, vs_last, hs_low_s, max_addr, blank_addr;

    // ---------------- reset ----------------
    rst_d = 1'b0; pix_en_d = 1'b0; enable_d = 1'b1;
    rst_s = 1'b0; pix_en_s = 1'b0; enable_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_en_d = (i != 1);
      step();
      chk("rst_hc", 32'(hc_d), 0);
      chk("rst_act", 32'(act_d), 0);
    end
    chk("rst_vc", 32'(vc_d), 0);
    chk("rst_hs", 32'(hs_d), 1);
    chk("rst_vs", 32'(vs_d), 1);
    chk("rst_vo", 32'(vo_d), 0);
    chk("rst_addr", 32'(addr_d), 0);
    chk("rst_fs", 32'(fs_d), 0);
    chk("rst_ls", 32'(ls_d), 0);
    chk("rst_s_hs", 32'(hs_s), 1);

    rst_d = 1'b1; pix_en_d = 1'b0;
    step();
    chk("idle_act", 32'(act_d), 0);
    chk("idle_fs", 32'(fs_d), 0);
    pix_en_d = 1'b1;
    step();
    start_cyc = cyc;
    chk("start_fs", 32'(fs_d), 1);
    chk("start_ls", 32'(ls_d), 1);
    chk("start_act", 32'(act_d), 1);
    chk("start_hc", 32'(hc_d), 0);
    chk("start_vo", 32'(vo_d), 1);
    chk("start_hs", 32'(hs_d), 1);
    pix_en_d = 1'b0;
    step();
    chk("start_fs_pulse", 32'(fs_d), 0);
    chk("start_ls_pulse", 32'(ls_d), 0);
    step();
    step();

    // ---------------- one line, strobe every 4th cycle ----------------
    hs_low = 0; hs_first = -1; hs_last = -1; vo_cnt = 0; vo_max = -1; ls_cyc = -1; ls_wide = 0;
    for (int k = 1; k <= 800; k++) begin
      pix_en_d = 1'b1;
      step();
      if (hs_d === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(hc_d);
        hs_last = int'(hc_d);
      end
      if (vo_d === 1'b1) begin
        vo_cnt++;
        if (int'(hc_d) > vo_max) vo_max = int'(hc_d);
      end
      if (ls_d === 1'b1) ls_cyc = cyc;
      pix_en_d = 1'b0;
      for (int g = 0; g < 3; g++) begin
        step();
        if (ls_d !== 1'b0) ls_wide++;
      end
    end
    chk("line_hs_low", hs_low, 96);
    chk("line_hs_first", hs_first, 656);
    chk("line_hs_last", hs_last, 751);
    chk("line_vo_cnt", vo_cnt, 640);
    chk("line_vo_max", vo_max, 639);
    chk("line_ls_period", ls_cyc - start_cyc, 3200);
    chk("line_ls_wide", ls_wide, 0);
    chk("line_hc", 32'(hc_d), 0);
    chk("line_vc", 32'(vc_d), 1);
    chk("line_addr", 32'(addr_d), 640);

    // ---------------- stall at HCOUNT=700 ----------------
    pix_en_d = 1'b1;
    for (int i = 0; i < 700; i++) step();
    chk("stall_hc", 32'(hc_d), 700);
    chk("stall_vc", 32'(vc_d), 1);
    chk("stall_hs", 32'(hs_d), 0);
    chk("stall_vo", 32'(vo_d), 0);
    chk("stall_addr", 32'(addr_d), 1280);
    pix_en_d = 1'b0;
    changed = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (hc_d !== 10'd700 || vc_d !== 10'd1 || hs_d !== 1'b0 || vs_d !== 1'b1 || vo_d !== 1'b0 ||
          addr_d !== 19'd1280 || ls_d !== 1'b0 || fs_d !== 1'b0 || act_d !== 1'b1) changed++;
    end
    chk("stall_frozen", changed, 0);
    pix_en_d = 1'b1;
    step();
    chk("resume_hc", 32'(hc_d), 701);
    chk("resume_hs", 32'(hs_d), 0);
    pix_en_d = 1'b0;

    // ---------------- small raster: full frame ----------------
    rst_s = 1'b1; enable_s = 1'b1; pix_en_s = 1'b1;
    step();
    fs0_cyc = cyc;
    chk("s_start_fs", 32'(fs_s), 1);
    chk("s_start_act", 32'(act_s), 1);
    bad_pos = 0; bad_vo = 0; bad_addr = 0; fs_cnt = 0; fs_cyc = -1;
    vs_low = 0; vs_first = -1; vs_last = -1; hs_low_s = 0; max_addr = -1; blank_addr = -1;
    for (int k = 1; k <= 160; k++) begin
      int ehc, evc;
      logic evo;
      step();
      ehc = (k % 160) % 16;
      evc = (k % 160) / 16;
      evo = (ehc < 8) && (evc < 6);
      if (hc_s !== 10'(ehc) || vc_s !== 10'(evc)) bad_pos++;
      if (vo_s !== evo) bad_vo++;
      if (evo && addr_s !== 6'(evc * 8 + ehc)) bad_addr++;
      if (hs_s === 1'b0) hs_low_s++;
      if (vs_s === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(vc_s);
        vs_last = int'(vc_s);
      end
      if (ehc == 7 && evc == 5) max_addr = int'(addr_s);
      if (ehc == 15 && evc == 9) blank_addr = int'(addr_s);
      if (fs_s === 1'b1) begin
        fs_cnt++;
        fs_cyc = cyc;
      end
    end
    chk("frame_pos", bad_pos, 0);
    chk("frame_vo", bad_vo, 0);
    chk("frame_addr_map", bad_addr, 0);
    chk("frame_hs_low", hs_low_s, 30);
    chk("frame_vs_low", vs_low, 32);
    chk("frame_vs_first", vs_first, 7);
    chk("frame_vs_last", vs_last, 8);
    chk("frame_addr_max", max_addr, 47);
    chk("frame_addr_blank", blank_addr, 47);
    chk("frame_addr_wrap", 32'(addr_s), 0);
    chk("frame_fs_cnt", fs_cnt, 1);
    chk("frame_fs_period", fs_cyc - fs0_cyc, 160);

    // ---------------- drop ENABLE and re-raise before frame end ----------------
    s_pos = 0; s_bad = 0;
    run_s(35);
    chk("rr_drop_hc", 32'(hc_s), 3);
    chk("rr_drop_vc", 32'(vc_s), 2);
    enable_s = 1'b0;
    run_s(45);
    chk("rr_raise_vc", 32'(vc_s), 5);
    enable_s = 1'b1;
    run_s(80);
    chk("rr_continuity", s_bad, 0);
    chk("rr_wrap_fs", 32'(fs_s), 1);
    chk("rr_wrap_act", 32'(act_s), 1);

    // ---------------- drop ENABLE and stop at frame end ----------------
    run_s(67);
    chk("stop_drop_hc", 32'(hc_s), 3);
    chk("stop_drop_vc", 32'(vc_s), 4);
    enable_s = 1'b0;
    run_s(92);
    chk("stop_continuity", s_bad, 0);
    chk("stop_last_hc", 32'(hc_s), 15);
    chk("stop_last_vc", 32'(vc_s), 9);
    step();
    chk("stop_idle_act", 32'(act_s), 0);
    chk("stop_idle_hc", 32'(hc_s), 0);
    chk("stop_idle_vc", 32'(vc_s), 0);
    chk("stop_no_fs", 32'(fs_s), 0);
    chk("stop_no_ls", 32'(ls_s), 0);
    chk("stop_idle_vo", 32'(vo_s), 0);
    step(); step(); step();
    chk("stop_stays_idle", 32'(act_s), 0);
    chk("stop_stays_hc", 32'(hc_s), 0);

    // ---------------- reset inside both sync pulses ----------------
    enable_s = 1'b1;
    step();
    chk("restart_fs", 32'(fs_s), 1);
    s_pos = 0; s_bad = 0;
    run_s(123);
    chk("sync_pos", s_bad, 0);
    chk("sync_hs_on", 32'(hs_s), 0);
    chk("sync_vs_on", 32'(vs_s), 0);
    rst_s = 1'b0;
    step();
    chk("mrst_hc", 32'(hc_s), 0);
    chk("mrst_vc", 32'(vc_s), 0);
    chk("mrst_hs", 32'(hs_s), 1);
    chk("mrst_vs", 32'(vs_s), 1);
    chk("mrst_vo", 32'(vo_s), 0);
    chk("mrst_act", 32'(act_s), 0);
    chk("mrst_addr", 32'(addr_s), 0);
    chk("mrst_fs", 32'(fs_s), 0);
    rst_s = 1'b1; pix_en_s = 1'b0;
    step();
    chk("mrst_idle_act", 32'(act_s), 0);
    chk("mrst_idle_hc", 32'(hc_s), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
